ebrick_umi_mem_responder: RTL and testbench
===========================================

EBRICK_UMI_MEM_RESPONDER -- requirements
Module: ebrick_umi_mem_responder

Interface
REQ-001 Parameters SHALL be:
- CW, default 32, UMI command width.
- AW, default 64, address width.
- DW, default 64, data width.
- DEPTH, default 64, number of DW-bit memory words.
- BASE, default 0, byte base address.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset:
- clk, input, 1, sole clock; all state updates on its rising edge.
- nreset, input, 1, asynchronous active-low reset.
REQ-003 Request inputs:
- udev_req_valid, input, 1, request valid.
- udev_req_cmd, input, CW, UMI command.
- udev_req_dstaddr, input, AW, target byte address.
- udev_req_srcaddr, input, AW, return address.
- udev_req_data, input, DW, write data.
REQ-004 Request ready: udev_req_ready, output, 1, request accepted when valid and ready are both high.
REQ-005 Response outputs:
- udev_resp_valid, output, 1, response valid.
- udev_resp_cmd, output, CW, response command.
- udev_resp_dstaddr, output, AW, response destination address.
- udev_resp_srcaddr, output, AW, response source address.
- udev_resp_data, output, DW, read data.
REQ-006 Response ready: udev_resp_ready, input, 1, downstream accepts the response.
REQ-007 Error counter: err_count, output, 8, saturating count of rejected requests.

Function
REQ-008 Command fields SHALL be decoded as follows:
- cmd[4:0] opcode: REQ_READ=0x01, REQ_WRITE=0x03, REQ_POSTED=0x05, RESP_READ=0x02, RESP_WRITE=0x04.
- cmd[7:5] size.
- cmd[15:8] len.
- cmd[25:24] err: 00 OK, 10 DEVERR.
REQ-009 udev_req_ready SHALL equal (!udev_resp_valid | udev_resp_ready), combinationally.
REQ-010 A non-posted request accepted in cycle N SHALL produce udev_resp_valid=1 in cycle N+1.
REQ-011 udev_resp_valid and all response fields SHALL hold stable until udev_resp_ready=1.
REQ-012 Response field mapping:
- resp cmd = req cmd with [4:0] set to the response opcode and [25:24] set to the err code.
- resp dstaddr = req srcaddr.
- resp srcaddr = req dstaddr.
REQ-013 Word index SHALL be (dstaddr-BASE)>>3; reads SHALL capture mem[index] into udev_resp_data at acceptance.
REQ-014 REQ_WRITE SHALL write mem[index] at acceptance and return RESP_WRITE with data=0.
REQ-015 REQ_POSTED SHALL write mem[index] and produce no response; the response register SHALL be unchanged except for clearing on a concurrent resp handshake.
REQ-016 On a simultaneous response handshake and new request acceptance in the same cycle, the new response SHALL load with no bubble, giving one transaction per cycle.
REQ-017 A read SHALL return the value of a write accepted in any earlier cycle.

Reset
REQ-018 With nreset=0: udev_resp_valid=0, all udev_resp_* fields=0, err_count=0.
REQ-019 Memory contents SHALL NOT be reset.
REQ-020 An in-flight response SHALL be dropped if reset is asserted mid-operation.
REQ-021 udev_req_ready SHALL be 1 during reset.

Configuration
REQ-022 The macro EBRICK_UMI_RESP_ERRCHK_EN SHALL control request checking.
REQ-023 With EBRICK_UMI_RESP_ERRCHK_EN defined, the following SHALL be rejected:
- size!=3, len!=0, or dstaddr[2:0]!=0;
- address outside [BASE, BASE+8*DEPTH);
- any opcode other than 0x01, 0x03 or 0x05.
REQ-024 A rejected request SHALL NOT modify memory; if non-posted, it SHALL return err=DEVERR with data=0, and err_count SHALL increment, saturating at 255.
REQ-025 A rejected request with an unknown opcode SHALL be answered with a RESP_WRITE-opcode DEVERR response.
REQ-026 Without EBRICK_UMI_RESP_ERRCHK_EN: no checks; index SHALL wrap modulo DEPTH; unknown opcodes SHALL be accepted and dropped; err_count SHALL be tied to 0.

Structure
REQ-027 Package ebrick_umi_pkg SHALL hold the opcode constants, cmd field bit positions and err codes.
REQ-028 Sub-module ebrick_umi_regmem SHALL be the DEPTH x DW storage array, with synchronous write and combinational read.

Verification
REQ-029 Write then read: REQ_WRITE dst=0x10 data=0xDEADBEEF_CAFEF00D src=0x8000 -> RESP_WRITE dst=0x8000 err=0; then REQ_READ dst=0x10 -> RESP_READ data=0xDEADBEEF_CAFEF00D.
REQ-030 Backpressure: udev_resp_ready=0 for 5 cycles after a read -> response held stable, udev_req_ready=0; release -> exactly one handshake.
REQ-031 Streaming: 8 back-to-back reads with udev_resp_ready=1 -> 8 responses in 8 consecutive cycles, in order.
REQ-032 Posted write: REQ_POSTED dst=0x18 data=0x55 -> no response; a following read of 0x18 returns 0x55.
REQ-033 With EBRICK_UMI_RESP_ERRCHK_EN: read dst=BASE+8*DEPTH -> err=DEVERR, err_count=1; a write with size=2 leaves memory unchanged.
REQ-034 Reset mid-operation: assert nreset while udev_resp_valid=1 -> udev_resp_valid=0 immediately (asynchronously), and no response after release.

Source files
------------

// File: rtl/ebrick_umi_pkg.sv
// ebrick_umi_pkg
//   Shared UMI definitions for the memory responder slice: opcode
//   encodings, command-word field positions, error codes and the
//   word-size constant that request checking accepts.
package ebrick_umi_pkg;

    // cmd[4:0] opcode encodings
    typedef enum logic [4:0] {
        UMI_REQ_READ   = 5'h01,
        UMI_RESP_READ  = 5'h02,
        UMI_REQ_WRITE  = 5'h03,
        UMI_RESP_WRITE = 5'h04,
        UMI_REQ_POSTED = 5'h05
    } umi_opcode_e;

    // cmd[25:24] error codes
    typedef enum logic [1:0] {
        UMI_ERR_OK     = 2'b00,
        UMI_ERR_DEVERR = 2'b10
    } umi_err_e;

    // Command field bit positions
    localparam int UMI_OPCODE_LSB = 0;
    localparam int UMI_OPCODE_MSB = 4;
    localparam int UMI_SIZE_LSB   = 5;
    localparam int UMI_SIZE_MSB   = 7;
    localparam int UMI_LEN_LSB    = 8;
    localparam int UMI_LEN_MSB    = 15;
    localparam int UMI_ERR_LSB    = 24;
    localparam int UMI_ERR_MSB    = 25;

    // size encoding for a single 8-byte word (2**3 bytes)
    localparam logic [2:0] UMI_SIZE_WORD = 3'd3;

    // True for the request opcodes this responder understands
    function automatic logic umi_is_known_req(input logic [4:0] op);
        return (op == UMI_REQ_READ) || (op == UMI_REQ_WRITE) ||
               (op == UMI_REQ_POSTED);
    endfunction

endpackage

// File: rtl/ebrick_umi_regmem.sv
// ebrick_umi_regmem
//   DEPTH x DW register-file storage with a single shared address:
//   synchronous write, combinational read. Contents are never reset.
// Ports:
//   clk    - write clock
//   we     - write enable
//   addr   - word index for both read and write
//   wdata  - write data
//   rdata  - combinational read of mem[addr] (pre-write value)
module ebrick_umi_regmem #(
    parameter int DW    = 64,
    parameter int DEPTH = 64,
    parameter int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [IW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/ebrick_umi_mem_responder.sv
// ebrick_umi_mem_responder
//   UMI device-side memory endpoint. Accepts read, write and posted-write
//   requests into a DEPTH x DW word memory and returns one registered
//   response per non-posted request, sustaining one transaction per cycle.
//
//   Build option: define EBRICK_UMI_RESP_ERRCHK_EN to enable request
//   checking (size/len/alignment/range/opcode), DEVERR responses and the
//   saturating err_count. Without it no checks are made, the word index
//   wraps modulo DEPTH, unknown opcodes are silently dropped and
//   err_count reads 0.
//
// Ports:
//   clk, nreset             - clock, asynchronous active-low reset
//   udev_req_valid/ready    - request handshake
//   udev_req_cmd/dstaddr/srcaddr/data - request fields
//   udev_resp_valid/ready   - response handshake
//   udev_resp_cmd/dstaddr/srcaddr/data - registered response fields
//   err_count               - saturating count of rejected requests
module ebrick_umi_mem_responder
    import ebrick_umi_pkg::*;
#(
    parameter int             CW    = 32,
    parameter int             AW    = 64,
    parameter int             DW    = 64,
    parameter int             DEPTH = 64,
    parameter logic [AW-1:0]  BASE  = '0
) (
    input  logic          clk,
    input  logic          nreset,
    // request
    input  logic          udev_req_valid,
    input  logic [CW-1:0] udev_req_cmd,
    input  logic [AW-1:0] udev_req_dstaddr,
    input  logic [AW-1:0] udev_req_srcaddr,
    input  logic [DW-1:0] udev_req_data,
    output logic          udev_req_ready,
    // response
    output logic          udev_resp_valid,
    output logic [CW-1:0] udev_resp_cmd,
    output logic [AW-1:0] udev_resp_dstaddr,
    output logic [AW-1:0] udev_resp_srcaddr,
    output logic [DW-1:0] udev_resp_data,
    input  logic          udev_resp_ready,
    // status
    output logic [7:0]    err_count
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic          accept;
    logic [4:0]    opcode;
    logic          is_read;
    logic          is_write;
    logic          is_posted;
    logic          reject;
    logic          respond;
    logic [AW-1:0] word;
    logic [IW-1:0] index;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;

    logic [4:0]    resp_op;
    logic [1:0]    resp_err;
    logic [CW-1:0] resp_cmd_next;
    logic [DW-1:0] resp_data_next;

    // Ready whenever the response slot is empty or draining this cycle;
    // resp_valid is 0 in reset so ready is 1 there as well.
    assign udev_req_ready = !udev_resp_valid || udev_resp_ready;
    assign accept         = udev_req_valid && udev_req_ready;

    assign opcode    = udev_req_cmd[UMI_OPCODE_MSB:UMI_OPCODE_LSB];
    assign is_read   = (opcode == UMI_REQ_READ);
    assign is_write  = (opcode == UMI_REQ_WRITE);
    assign is_posted = (opcode == UMI_REQ_POSTED);

    // Byte offset from BASE to word index. The modulo is identity for
    // in-range addresses and gives the wrap behaviour when unchecked.
    assign word  = (udev_req_dstaddr - BASE) >> 3;
    assign index = IW'(word % AW'(DEPTH));

`ifdef EBRICK_UMI_RESP_ERRCHK_EN
    localparam logic [AW:0] LIMIT = {1'b0, BASE} + (AW+1)'(8 * DEPTH);

    logic [2:0] size;
    logic [7:0] len;
    logic       bad_shape;
    logic       bad_range;
    logic [7:0] err_cnt;

    assign size      = udev_req_cmd[UMI_SIZE_MSB:UMI_SIZE_LSB];
    assign len       = udev_req_cmd[UMI_LEN_MSB:UMI_LEN_LSB];
    assign bad_shape = (size != UMI_SIZE_WORD) || (len != 8'd0) ||
                       (udev_req_dstaddr[2:0] != 3'b000);
    assign bad_range = (udev_req_dstaddr < BASE) ||
                       ({1'b0, udev_req_dstaddr} >= LIMIT);
    assign reject    = bad_shape || bad_range || !umi_is_known_req(opcode);

    // Every rejected request is answered except posted ones.
    assign respond   = !is_posted;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            err_cnt <= '0;
        end else if (accept && reject && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end

    assign err_count = err_cnt;
`else
    assign reject    = 1'b0;
    // Unknown opcodes are consumed without a response.
    assign respond   = is_read || is_write;
    assign err_count = '0;
`endif

    assign mem_we = accept && (is_write || is_posted) && !reject;

    ebrick_umi_regmem #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_regmem (
        .clk   (clk),
        .we    (mem_we),
        .addr  (index),
        .wdata (udev_req_data),
        .rdata (mem_rdata)
    );

    // Response content: reads answer RESP_READ, everything else that
    // gets a response (writes, unknown opcodes) answers RESP_WRITE.
    always_comb begin
        resp_op        = is_read ? UMI_RESP_READ : UMI_RESP_WRITE;
        resp_err       = reject ? UMI_ERR_DEVERR : UMI_ERR_OK;
        resp_data_next = (is_read && !reject) ? mem_rdata : '0;
        resp_cmd_next  = udev_req_cmd;
        resp_cmd_next[UMI_OPCODE_MSB:UMI_OPCODE_LSB] = resp_op;
        resp_cmd_next[UMI_ERR_MSB:UMI_ERR_LSB]       = resp_err;
    end

    // A new load takes priority over a concurrent drain so back-to-back
    // requests stream with no bubble; a drain alone only clears valid.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            udev_resp_valid   <= 1'b0;
            udev_resp_cmd     <= '0;
            udev_resp_dstaddr <= '0;
            udev_resp_srcaddr <= '0;
            udev_resp_data    <= '0;
        end else if (accept && respond) begin
            udev_resp_valid   <= 1'b1;
            udev_resp_cmd     <= resp_cmd_next;
            udev_resp_dstaddr <= udev_req_srcaddr;
            udev_resp_srcaddr <= udev_req_dstaddr;
            udev_resp_data    <= resp_data_next;
        end else if (udev_resp_valid && udev_resp_ready) begin
            udev_resp_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ebrick_umi_mem_responder.sv
// tb_ebrick_umi_mem_responder
//   Directed self-checking bench for ebrick_umi_mem_responder with
//   hand-computed expected values. Sections guarded by
//   EBRICK_UMI_RESP_ERRCHK_EN follow the DUT build option.
module tb_ebrick_umi_mem_responder;

    localparam int          CW    = 32;
    localparam int          AW    = 64;
    localparam int          DW    = 64;
    localparam int          DEPTH = 64;
    localparam logic [63:0] BASE  = 64'h0;

    // Expected command words (size=3, len=0)
    localparam logic [31:0] C_RD    = 32'h0000_0061;
    localparam logic [31:0] C_WR    = 32'h0000_0063;
    localparam logic [31:0] C_PW    = 32'h0000_0065;
    localparam logic [31:0] C_RRESP = 32'h0000_0062;
    localparam logic [31:0] C_WRESP = 32'h0000_0064;

    logic          clk;
    logic          nreset;
    logic          udev_req_valid;
    logic [CW-1:0] udev_req_cmd;
    logic [AW-1:0] udev_req_dstaddr;
    logic [AW-1:0] udev_req_srcaddr;
    logic [DW-1:0] udev_req_data;
    logic          udev_req_ready;
    logic          udev_resp_valid;
    logic [CW-1:0] udev_resp_cmd;
    logic [AW-1:0] udev_resp_dstaddr;
    logic [AW-1:0] udev_resp_srcaddr;
    logic [DW-1:0] udev_resp_data;
    logic          udev_resp_ready;
    logic [7:0]    err_count;

    int n_checks = 0;
    int n_fails  = 0;
    int hs_count = 0;
    int hs_snap;

    ebrick_umi_mem_responder #(
        .CW    (CW),
        .AW    (AW),
        .DW    (DW),
        .DEPTH (DEPTH),
        .BASE  (BASE)
    ) dut (
        .clk               (clk),
        .nreset            (nreset),
        .udev_req_valid    (udev_req_valid),
        .udev_req_cmd      (udev_req_cmd),
        .udev_req_dstaddr  (udev_req_dstaddr),
        .udev_req_srcaddr  (udev_req_srcaddr),
        .udev_req_data     (udev_req_data),
        .udev_req_ready    (udev_req_ready),
        .udev_resp_valid   (udev_resp_valid),
        .udev_resp_cmd     (udev_resp_cmd),
        .udev_resp_dstaddr (udev_resp_dstaddr),
        .udev_resp_srcaddr (udev_resp_srcaddr),
        .udev_resp_data    (udev_resp_data),
        .udev_resp_ready   (udev_resp_ready),
        .err_count         (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count response handshakes as seen at the clock edge
    always @(posedge clk) begin
        if (nreset && udev_resp_valid && udev_resp_ready) begin
            hs_count++;
        end
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mkcmd(input logic [4:0] op,
                                          input logic [2:0] size,
                                          input logic [7:0] len);
        return {16'h0, len, size, op};
    endfunction

    function automatic logic [63:0] pat(input int i);
        return 64'h0123_4567_89AB_CD00 + 64'(i);
    endfunction

    task automatic drive(input logic [31:0] cmd, input logic [63:0] dst,
                         input logic [63:0] src, input logic [63:0] data);
        udev_req_valid   = 1'b1;
        udev_req_cmd     = cmd;
        udev_req_dstaddr = dst;
        udev_req_srcaddr = src;
        udev_req_data    = data;
    endtask

    task automatic idle();
        udev_req_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        nreset           = 1'b0;
        udev_req_valid   = 1'b0;
        udev_req_cmd     = '0;
        udev_req_dstaddr = '0;
        udev_req_srcaddr = '0;
        udev_req_data    = '0;
        udev_resp_ready  = 1'b1;

        // Reset state
        #2;
        check("rst_valid", 64'(udev_resp_valid), 64'd0);
        check("rst_cmd",   64'(udev_resp_cmd), 64'd0);
        check("rst_dst",   udev_resp_dstaddr, 64'd0);
        check("rst_src",   udev_resp_srcaddr, 64'd0);
        check("rst_data",  udev_resp_data, 64'd0);
        check("rst_errc",  64'(err_count), 64'd0);
        check("rst_ready", 64'(udev_req_ready), 64'd1);
        repeat (2) @(posedge clk);
        #1 nreset = 1'b1;

        // Write then read
        drive(C_WR, 64'h10, 64'h8000, 64'hDEADBEEF_CAFEF00D);
        check("wr_ready", 64'(udev_req_ready), 64'd1);
        tick();
        check("wr_valid", 64'(udev_resp_valid), 64'd1);
        check("wr_cmd",   64'(udev_resp_cmd), 64'(C_WRESP));
        check("wr_dst",   udev_resp_dstaddr, 64'h8000);
        check("wr_src",   udev_resp_srcaddr, 64'h10);
        check("wr_data",  udev_resp_data, 64'h0);
        drive(C_RD, 64'h10, 64'h8000, 64'h0);
        tick();
        check("rd_valid", 64'(udev_resp_valid), 64'd1);
        check("rd_cmd",   64'(udev_resp_cmd), 64'(C_RRESP));
        check("rd_dst",   udev_resp_dstaddr, 64'h8000);
        check("rd_src",   udev_resp_srcaddr, 64'h10);
        check("rd_data",  udev_resp_data, 64'hDEADBEEF_CAFEF00D);
        idle();
        tick();
        check("rd_drain", 64'(udev_resp_valid), 64'd0);

        // Backpressure
        udev_resp_ready = 1'b0;
        hs_snap = hs_count;
        drive(C_RD, 64'h10, 64'h9000, 64'h0);
        tick();
        idle();
        check("bp_valid0", 64'(udev_resp_valid), 64'd1);
        check("bp_ready0", 64'(udev_req_ready), 64'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid", 64'(udev_resp_valid), 64'd1);
            check("bp_data",  udev_resp_data, 64'hDEADBEEF_CAFEF00D);
            check("bp_dst",   udev_resp_dstaddr, 64'h9000);
            check("bp_ready", 64'(udev_req_ready), 64'd0);
        end
        udev_resp_ready = 1'b1;
        #1;
        check("bp_rel_ready", 64'(udev_req_ready), 64'd1);
        tick();
        check("bp_rel_valid", 64'(udev_resp_valid), 64'd0);
        tick();
        check("bp_hs", 64'(hs_count - hs_snap), 64'd1);

        // Streaming: 8 writes then 8 back-to-back reads
        for (int i = 0; i < 8; i++) begin
            drive(C_WR, 64'h40 + 64'(8 * i), 64'h100 + 64'(i), pat(i));
            tick();
            check("st_wr_cmd", 64'(udev_resp_cmd), 64'(C_WRESP));
        end
        for (int i = 0; i < 8; i++) begin
            drive(C_RD, 64'h40 + 64'(8 * i), 64'h200 + 64'(i), 64'h0);
            tick();
            if (i == 0) hs_snap = hs_count;
            check("st_rd_valid", 64'(udev_resp_valid), 64'd1);
            check("st_rd_data",  udev_resp_data, pat(i));
            check("st_rd_src",   udev_resp_srcaddr, 64'h40 + 64'(8 * i));
        end
        idle();
        tick();
        check("st_hs", 64'(hs_count - hs_snap), 64'd8);

        // Posted write: no response, then readback
        hs_snap = hs_count;
        drive(C_PW, 64'h18, 64'h300, 64'h55);
        tick();
        idle();
        check("pw_valid0", 64'(udev_resp_valid), 64'd0);
        tick();
        check("pw_valid1", 64'(udev_resp_valid), 64'd0);
        check("pw_hs", 64'(hs_count - hs_snap), 64'd0);
        drive(C_RD, 64'h18, 64'h300, 64'h0);
        tick();
        idle();
        check("pw_rd_cmd",  64'(udev_resp_cmd), 64'(C_RRESP));
        check("pw_rd_data", udev_resp_data, 64'h55);
        tick();

`ifdef EBRICK_UMI_RESP_ERRCHK_EN
        // Last valid word is accepted
        drive(C_WR, BASE + 64'(8 * DEPTH - 8), 64'h400, 64'h77);
        tick();
        check("ec_last_cmd", 64'(udev_resp_cmd), 64'(C_WRESP));
        // First word past the end is rejected
        drive(C_RD, BASE + 64'(8 * DEPTH), 64'h400, 64'h0);
        tick();
        check("ec_oor_cmd",  64'(udev_resp_cmd), 64'h0200_0062);
        check("ec_oor_data", udev_resp_data, 64'h0);
        check("ec_oor_errc", 64'(err_count), 64'd1);
        // size=2 write rejected, memory untouched
        drive(mkcmd(5'h03, 3'd2, 8'd0), 64'h10, 64'h400, 64'h1234);
        tick();
        check("ec_sz_cmd",  64'(udev_resp_cmd), 64'h0200_0044);
        check("ec_sz_errc", 64'(err_count), 64'd2);
        drive(C_RD, 64'h10, 64'h400, 64'h0);
        tick();
        check("ec_sz_rd", udev_resp_data, 64'hDEADBEEF_CAFEF00D);
        // Unknown opcode answered as RESP_WRITE DEVERR
        drive(mkcmd(5'h07, 3'd3, 8'd0), 64'h10, 64'h400, 64'h0);
        tick();
        idle();
        check("ec_unk_cmd",  64'(udev_resp_cmd), 64'h0200_0064);
        check("ec_unk_errc", 64'(err_count), 64'd3);
`else
        // Index wraps modulo DEPTH: 0x210 aliases 0x10
        drive(C_WR, 64'h10 + 64'(8 * DEPTH), 64'h400, 64'hA5A5_5A5A_0F0F_F0F0);
        tick();
        drive(C_RD, 64'h10, 64'h400, 64'h0);
        tick();
        check("wrap_data", udev_resp_data, 64'hA5A5_5A5A_0F0F_F0F0);
        // Unknown opcode accepted and dropped
        drive(mkcmd(5'h07, 3'd3, 8'd0), 64'h10, 64'h400, 64'h0);
        check("unk_ready", 64'(udev_req_ready), 64'd1);
        tick();
        idle();
        check("unk_valid", 64'(udev_resp_valid), 64'd0);
        check("errc_zero", 64'(err_count), 64'd0);
`endif
        tick();

        // Reset mid-operation
        udev_resp_ready = 1'b0;
        drive(C_RD, 64'h18, 64'h500, 64'h0);
        tick();
        idle();
        check("mr_valid", 64'(udev_resp_valid), 64'd1);
        #2 nreset = 1'b0;
        #1;
        check("mr_async_valid", 64'(udev_resp_valid), 64'd0);
        check("mr_async_data",  udev_resp_data, 64'h0);
        check("mr_ready",       64'(udev_req_ready), 64'd1);
        check("mr_errc",        64'(err_count), 64'd0);
        repeat (2) @(posedge clk);
        #1 nreset = 1'b1;
        udev_resp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mr_no_resp", 64'(udev_resp_valid), 64'd0);
        end
        // Memory survives reset
        drive(C_RD, 64'h18, 64'h500, 64'h0);
        tick();
        idle();
        check("mr_mem_kept", udev_resp_data, 64'h55);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
